// File: rtl/alu_issue.sv
// Issue/operand stage for the registered 64-bit ALU. It selects operands with E2 forwarding,
// stalls on a dependency against the op in E1, and returns the ALU result for writeback.
module alu_issue #(
  parameter int XLEN = 64,
  parameter int RW   = 5,
  parameter int CW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [RW-1:0]   in_rd,
  input  logic [RW-1:0]   in_rs1,
  input  logic [RW-1:0]   in_rs2,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_imm,
  input  logic [5:0]      in_shamt,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [2:0]      Sel,
  output logic [5:0]      Shiftamt,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [CW-1:0]   issue_cnt,
  output logic [CW-1:0]   stall_cnt
);
  typedef struct packed {
    logic          vld;
    logic [RW-1:0] rd;
  } stg_t;

  localparam logic [2:0] SEL_ZERO = 3'd7;

  stg_t            e1_q, e2_q;
  logic [XLEN-1:0] a_q, b_q, opa_d, opb_d;
  logic [2:0]      sel_q;
  logic [5:0]      sh_q;
  logic [CW-1:0]   issue_q, stall_q;
  logic            dep1, dep2, acc;

  // The E1 result is not out of the ALU yet, so a match there costs one bubble.
  assign dep1     = e1_q.vld && (e1_q.rd != '0) && (in_rs1 == e1_q.rd);
  assign dep2     = !in_use_imm && e1_q.vld && (e1_q.rd != '0) && (in_rs2 == e1_q.rd);
  assign in_ready = !(dep1 || dep2);
  assign acc      = in_valid && in_ready;

  always_comb begin
    opa_d = rs1_data;
    if (in_rs1 == '0)                          opa_d = '0;
    else if (e2_q.vld && (in_rs1 == e2_q.rd))  opa_d = alu_result;
    opb_d = rs2_data;
    if (in_rs2 == '0)                          opb_d = '0;
    else if (e2_q.vld && (in_rs2 == e2_q.rd))  opb_d = alu_result;
    if (in_use_imm)                            opb_d = in_imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= SEL_ZERO;
      sh_q    <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      e2_q <= e1_q;
      if (acc) begin
        a_q     <= opa_d;
        b_q     <= opb_d;
        sel_q   <= in_op;
        sh_q    <= in_shamt;
        e1_q    <= '{vld: 1'b1, rd: in_rd};
      end else begin
        e1_q.vld <= 1'b0;
        sel_q    <= SEL_ZERO;
      end
      if (acc)                   issue_q <= issue_q + {{(CW-1){1'b0}}, 1'b1};
      if (in_valid && !in_ready) stall_q <= stall_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign Sel       = sel_q;
  assign Shiftamt  = sh_q;
  assign wb_valid  = e2_q.vld;
  assign wb_rd     = e2_q.rd;
  assign wb_data   = alu_result;
  assign issue_cnt = issue_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: registered ALU model, register file and in-order architectural model.
module tb_alu_issue;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_use_imm;
  logic [2:0]  in_op, Sel;
  logic [4:0]  in_rd, in_rs1, in_rs2, wb_rd;
  logic [63:0] in_imm, rs1_data, rs2_data, A, B, alu_result, wb_data;
  logic [5:0]  in_shamt, Shiftamt;
  logic        wb_valid;
  logic [31:0] issue_cnt, stall_cnt;
  logic        w_ready, w_wbv;
  logic [63:0] w_A, w_B, w_wbd;
  logic [2:0]  w_Sel;
  logic [5:0]  w_sh;
  logic [4:0]  w_wbrd;
  logic [3:0]  w_issue, w_stall;

  logic [63:0] rf [32];
  logic [63:0] arch [32];
  logic        ovr1;
  logic [63:0] ovr1_val;
  int          edges = 0;
  int          total = 0, bad = 0;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_shamt(in_shamt), .rs1_data(rs1_data), .rs2_data(rs2_data), .A(A), .B(B), .Sel(Sel),
    .Shiftamt(Shiftamt), .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt));

  alu_issue #(.CW(4)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_shamt(in_shamt), .rs1_data(rs1_data), .rs2_data(rs2_data), .A(w_A), .B(w_B), .Sel(w_Sel),
    .Shiftamt(w_sh), .alu_result(alu_result), .wb_valid(w_wbv), .wb_rd(w_wbrd),
    .wb_data(w_wbd), .issue_cnt(w_issue), .stall_cnt(w_stall));

  function automatic logic [63:0] alu_f(logic [2:0] op, logic [63:0] a, logic [63:0] b, logic [5:0] sh);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return ~(a ^ b);
      3'd4: return a & b;
      3'd5: return ~a;
      3'd6: return a << sh;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] seed(int i);
    if (i == 0) return 64'd0;
    if (i == 1) return 64'd10;
    if (i == 2) return 64'd32;
    return 64'(i) * 64'h0101 + 64'd100;
  endfunction

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    alu_result <= alu_f(Sel, A, B, Shiftamt);
    edges <= edges + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 32; i++) rf[i] <= seed(i);
    else if (wb_valid && wb_rd != 0) rf[wb_rd] <= wb_data;
  end

  assign rs1_data = ovr1 ? ovr1_val : rf[in_rs1];
  assign rs2_data = rf[in_rs2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] op, input logic [4:0] rd, input logic [4:0] r1,
                     input logic [4:0] r2, input logic ie, input logic [63:0] im, input logic [5:0] sh);
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = r1; in_rs2 = r2;
    in_use_imm = ie; in_imm = im; in_shamt = sh;
  endtask

  task automatic idle();
    drv(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 6'd0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic [4:0] pre_rd;
    logic [4:0] rs1, rs2;
    logic       imm;
    logic       exp_ready;
  } hz_t;
  hz_t tbl [6];

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_t;
  wb_t wq[$];

  logic        prev_acc;
  logic [4:0]  prev_rd;
  logic [63:0] ea, eb, res;
  logic [2:0]  esel;
  logic [5:0]  esh;
  int          n_iss, n_stall;
  logic        er;

  initial begin
    rst_n = 0; ovr1 = 0; ovr1_val = 0;
    idle();
    tbl[0] = '{5'd3, 5'd3, 5'd0, 1'b0, 1'b0};
    tbl[1] = '{5'd3, 5'd0, 5'd3, 1'b0, 1'b0};
    tbl[2] = '{5'd3, 5'd1, 5'd3, 1'b1, 1'b1};
    tbl[3] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1};
    tbl[4] = '{5'd5, 5'd1, 5'd2, 1'b0, 1'b1};
    tbl[5] = '{5'd7, 5'd7, 5'd7, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_A", A, 0); chk("rst_B", B, 0); chk("rst_Sel", Sel, 7); chk("rst_sh", Shiftamt, 0);
    chk("rst_wbv", wb_valid, 0); chk("rst_iss", issue_cnt, 0); chk("rst_stall", stall_cnt, 0);
    rst_n = 1;

    // single add r3 = r1 + r2
    @(negedge clk); drv(1, 0, 3, 1, 2, 0, 0, 0); #1 chk("add_rdy", in_ready, 1);
    @(negedge clk); idle();
    chk("add_A", A, 10); chk("add_B", B, 32); chk("add_Sel", Sel, 0); chk("add_wb0", wb_valid, 0);
    @(negedge clk);
    chk("add_wbv", wb_valid, 1); chk("add_wbrd", wb_rd, 3); chk("add_wbd", wb_data, 42);

    // forward from E2 with a stale register-file read
    @(negedge clk); drv(1, 0, 3, 1, 2, 0, 0, 0);
    @(negedge clk); idle();
    @(negedge clk); drv(1, 1, 4, 3, 2, 0, 0, 0); ovr1 = 1; ovr1_val = 0; #1 chk("fwd_rdy", in_ready, 1);
    @(negedge clk); idle(); ovr1 = 0;
    chk("fwd_A", A, 42); chk("fwd_B", B, 32); chk("fwd_Sel", Sel, 1);
    @(negedge clk);
    chk("fwd_wbv", wb_valid, 1); chk("fwd_wbrd", wb_rd, 4); chk("fwd_wbd", wb_data, 10);

    // reset with an op in flight
    @(negedge clk); drv(1, 0, 7, 1, 2, 0, 0, 0);
    @(negedge clk); idle(); #1 rst_n = 0; #1;
    chk("mrst_A", A, 0); chk("mrst_B", B, 0); chk("mrst_Sel", Sel, 7);
    chk("mrst_wbv", wb_valid, 0); chk("mrst_iss", issue_cnt, 0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("mrst_nowb", wb_valid, 0); end

    // back-to-back dependency: one stall, then forward
    @(negedge clk); drv(1, 0, 3, 1, 2, 0, 0, 0); #1 chk("b2b_rdy0", in_ready, 1);
    @(negedge clk); drv(1, 4, 5, 3, 3, 0, 0, 0); #1 chk("b2b_stall", in_ready, 0);
    @(negedge clk); #1 chk("b2b_rdy1", in_ready, 1); chk("b2b_scnt", stall_cnt, 1);
    chk("b2b_wb3", wb_valid, 1); chk("b2b_wbd3", wb_data, 42);
    @(negedge clk); idle();
    chk("b2b_A", A, 42); chk("b2b_B", B, 42); chk("b2b_Sel", Sel, 4); chk("b2b_icnt", issue_cnt, 2);
    @(negedge clk); chk("b2b_wbrd5", wb_rd, 5); chk("b2b_wbd5", wb_data, 42);

    // immediate shift ignores rs2 hazard; r0 never hazards
    @(negedge clk); drv(1, 0, 3, 1, 2, 0, 0, 0);
    @(negedge clk); drv(1, 6, 6, 1, 3, 1, 64'd5, 6'd4); #1 chk("imm_rdy", in_ready, 1);
    @(negedge clk); idle();
    chk("imm_sh", Shiftamt, 4); chk("imm_Sel", Sel, 6); chk("imm_A", A, 10); chk("imm_B", B, 5);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drv(1, 2, 9, 0, 1, 0, 0, 0); #1 chk("r0_rdy", in_ready, 1);
    @(negedge clk); idle(); chk("r0_A", A, 0);
    chk("r0_wbv", wb_valid, 1); chk("r0_wbrd", wb_rd, 0);

    // hazard table
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); drv(1, 0, tbl[k].pre_rd, 0, 0, 0, 0, 0);
      @(negedge clk); drv(1, 2, 5'd8, tbl[k].rs1, tbl[k].rs2, tbl[k].imm, 64'd1, 0);
      #1 chk($sformatf("tbl%0d_rdy", k), in_ready, tbl[k].exp_ready);
      @(negedge clk); idle();
      @(negedge clk);
    end

    // counter wrap at CW=4
    do_reset();
    for (int k = 0; k < 17; k++) begin @(negedge clk); drv(1, 7, 0, 0, 0, 0, 0, 0); end
    @(negedge clk); idle();
    chk("wrap_w", w_issue, 1); chk("wrap_full", issue_cnt, 17);

    // randomized run against the architectural model
    do_reset();
    for (int i = 0; i < 32; i++) arch[i] = seed(i);
    prev_acc = 0; prev_rd = 0; n_iss = 0; n_stall = 0; esel = 7; ea = 0; eb = 0; esh = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (wq.size() > 0 && wq[0].due == edges) begin
        chk("rnd_wbv", wb_valid, 1); chk("rnd_wbrd", wb_rd, wq[0].rd); chk("rnd_wbd", wb_data, wq[0].data);
        void'(wq.pop_front());
      end else chk("rnd_wbv0", wb_valid, 0);
      chk("rnd_Sel", Sel, esel);
      if (prev_acc) begin chk("rnd_A", A, ea); chk("rnd_B", B, eb); chk("rnd_sh", Shiftamt, esh); end
      if (c >= 590) idle();
      else drv($urandom_range(3) != 0, 3'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
               5'($urandom_range(7)), $urandom_range(3) == 0, {$urandom, $urandom}, 6'($urandom_range(63)));
      #1;
      er = !(prev_acc && prev_rd != 0 && (in_rs1 == prev_rd || (!in_use_imm && in_rs2 == prev_rd)));
      chk("rnd_rdy", in_ready, er);
      if (in_valid && !er) n_stall++;
      if (in_valid && er) begin
        ea = (in_rs1 == 0) ? 64'd0 : arch[in_rs1];
        eb = in_use_imm ? in_imm : ((in_rs2 == 0) ? 64'd0 : arch[in_rs2]);
        esel = in_op; esh = in_shamt;
        res = alu_f(in_op, ea, eb, in_shamt);
        if (in_rd != 0) arch[in_rd] = res;
        wq.push_back('{edges + 2, in_rd, res});
        prev_acc = 1; prev_rd = in_rd; n_iss++;
      end else begin
        prev_acc = 0; esel = 7;
      end
    end
    @(negedge clk);
    chk("rnd_qempty", 64'(wq.size()), 0);
    chk("rnd_icnt", issue_cnt, 32'(n_iss));
    chk("rnd_scnt", stall_cnt, 32'(n_stall));
    chk("rnd_wcnt", w_issue, 4'(n_iss));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue/operand stage that drives the registered 64-bit ALU (operands A/B, Sel, Shiftamt) and collects its result one cycle later for writeback.
- Sits between decode/register-file read and the ALU. Accepts one decoded op per cycle over a valid/ready handshake.
- Forwards the ALU result to the next op and stalls on a back-to-back dependency.
- Keeps issue and stall counters.

Parameters:
- XLEN, 64, operand/result width
- RW, 5, register index width
- CW, 32, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded op offered
- in_ready  out  1  op accepted this cycle when in_valid&&in_ready
- in_op  in  3  ALU select: 0 add, 1 sub, 2 or, 3 xnor, 4 and, 5 comp, 6 shift, 7 zero
- in_rd  in  RW  destination register
- in_rs1  in  RW  source register 1
- in_rs2  in  RW  source register 2
- in_use_imm  in  1  B taken from in_imm instead of rs2
- in_imm  in  XLEN  immediate
- in_shamt  in  6  shift amount
- rs1_data  in  XLEN  register-file read of in_rs1
- rs2_data  in  XLEN  register-file read of in_rs2
- A  out  XLEN  ALU operand A (registered)
- B  out  XLEN  ALU operand B (registered)
- Sel  out  3  ALU select (registered)
- Shiftamt  out  6  ALU shift amount (registered)
- alu_result  in  XLEN  ALU registered Output
- wb_valid  out  1  writeback valid
- wb_rd  out  RW  writeback destination
- wb_data  out  XLEN  writeback data (= alu_result)
- issue_cnt  out  CW  accepted ops
- stall_cnt  out  CW  cycles with in_valid && !in_ready

Behaviour:
- Reset: asynchronous, active-low, clk and rst_n as named above.
  - A=0, B=0, Sel=7, Shiftamt=0.
  - e1_valid=0, e1_rd=0, e2_valid=0, e2_rd=0.
  - wb_valid=0, wb_rd=0, issue_cnt=0, stall_cnt=0.
  - Reset mid-operation discards in-flight ops. No writeback is emitted after reset deasserts until a new issue.
- Pipeline:
  - Edge N (accept): A, B, Sel, Shiftamt, e1_rd load; e1_valid=1.
  - Edge N+1: the ALU registers its Output; e2_valid<=e1_valid, e2_rd<=e1_rd.
  - Cycle after edge N+1: wb_valid=e2_valid, wb_rd=e2_rd, wb_data=alu_result (combinational pass-through). Writeback latency is 2 edges after accept.
- Bubble: on an edge with no accept, e1_valid<=0, Sel<=7, and A/B/Shiftamt hold.
- Operand select: per source, first match wins.
  - rs==0 -> 0.
  - Else e2_valid && rs==e2_rd -> alu_result (forward).
  - Else register-file data.
  - B: in_use_imm ? in_imm : rs2 path. rs2 is ignored for hazard when in_use_imm=1.
- Hazard: dep1 = e1_valid && e1_rd!=0 && in_rs1==e1_rd. dep2 is the same test on in_rs2, active only when !in_use_imm.
  - in_ready = !(dep1||dep2), combinational, independent of in_valid.
  - A stall lasts exactly 1 cycle, after which the dependency resolves via forwarding.
- Register file writes wb_data at the edge ending the wb cycle. The register file covers any later read; no further bypass is needed.
- in_rd==0: the op is issued and wb_valid asserts with wb_rd=0. It never creates a hazard and is never forwarded.
- issue_cnt increments on accept. stall_cnt increments on in_valid && !in_ready. Both wrap modulo 2^CW.
- in_valid low: in_ready is still driven by the hazard logic. stall_cnt does not count.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-stream -> immediately A=0, B=0, Sel=7, wb_valid=0, counters=0.
  - Release -> no wb_valid until a new accept.
- Single add:
  - Issue add rd=3, rs1=1 (10), rs2=2 (32) -> next cycle A=10, B=32, Sel=0.
  - Two edges after accept: wb_valid=1, wb_rd=3, wb_data=42.
- Forward from E2:
  - add r3=10+32, then bubble, then sub r4=r3-r2 with rs1_data stale (0) -> A=42 (forwarded), B=32.
  - No stall; wb_data=10.
- Back-to-back hazard:
  - add r3, then immediately and r5=r3&r3 -> in_ready=0 for one cycle, stall_cnt=1.
  - Next cycle accepted with A=B=42 forwarded.
  - issue_cnt=2.
- Immediate/shift and r0:
  - shift rd=6, rs1=1, in_use_imm=1, in_shamt=4, with rs2 matching the in-flight rd -> no stall, Shiftamt=4.
  - Op with rs1=0 while e1_rd=0 -> no stall, A=0.
- Counter wrap:
  - CW=4, 17 accepts -> issue_cnt=1.
